muldiv_unit: RTL

Iterative 32-bit multiply/divide unit for the MIPS core. It sits directly downstream of the register file. It takes the two read-port values (rdata1 → a, rdata2 → b) for MULT/MULTU/DIV/DIVU and holds the architectural HI/LO registers. MFHI/MFLO read HI/LO back into the register-file write path. MTHI/MTLO write HI/LO directly.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_abs.sv | 13 +
 rtl/muldiv_unit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit:
// operation codes, FSM states and the default iteration count.
package muldiv_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_abs.sv
// Conditional two's-complement negate: yields |x| when neg_i flags a negative
// signed input, and applies result sign correction when neg_i is the sign flag.
module muldiv_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);

    assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO
// registers; one shift-add or restoring-divide step per clock on magnitudes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = MD_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W = $clog2(ITER);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(ITER - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

    logic               is_div_q, neg_res_q, neg_rem_q, dbz_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;

    op_e                op_in;
    logic               load_en, step_en, fix_en, idle_wr;
    logic               signed_op, is_div;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, rem_shift, div_diff;
    logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, hi_res, lo_res;

    assign op_in     = op_e'(op);
    assign signed_op = (op_in == OP_MULT) || (op_in == OP_DIV);
    assign is_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);

    // Magnitudes are unsigned W-bit, so |0x80000000| = 0x80000000 stays exact.
    muldiv_abs #(.W(WIDTH)) u_abs_a (
        .val_i(a), .neg_i(signed_op & a[WIDTH-1]), .val_o(a_mag)
    );
    muldiv_abs #(.W(WIDTH)) u_abs_b (
        .val_i(b), .neg_i(signed_op & b[WIDTH-1]), .val_o(b_mag)
    );

    always_comb begin
        state_d = state_q;
        load_en = 1'b0;
        step_en = 1'b0;
        fix_en  = 1'b0;
        idle_wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_en = 1'b1;
                    state_d = CALC;
                end else begin
                    idle_wr = 1'b1;
                end
            end
            CALC: begin
                step_en = 1'b1;
                if (count_q == LAST) state_d = FIX;
            end
            FIX: begin
                fix_en  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // acc holds {upper, lower}: multiplier or dividend shifts out of the lower half.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
        rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = rem_shift - {1'b0, mcand_q};
        if (div_diff[WIDTH]) div_step = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        else                 div_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

        acc_d = acc_q;
        if (load_en)      acc_d = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
        else if (step_en) acc_d = is_div_q ? div_step : mul_step;
    end

    muldiv_abs #(.W(2*WIDTH)) u_fix_prod (
        .val_i(acc_q), .neg_i(neg_res_q & ~is_div_q), .val_o(prod_fix)
    );
    muldiv_abs #(.W(WIDTH)) u_fix_quo (
        .val_i(acc_q[WIDTH-1:0]), .neg_i(neg_res_q), .val_o(quo_fix)
    );
    muldiv_abs #(.W(WIDTH)) u_fix_rem (
        .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .val_o(rem_fix)
    );

    // Divide by zero leaves rem = |a|, so sign correction restores HI = a; only LO is forced.
    assign hi_res = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign lo_res = is_div_q ? (dbz_q ? '1 : quo_fix) : prod_fix[WIDTH-1:0];

    always_comb begin
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = fix_en;
        if (load_en)      count_d = '0;
        else if (step_en) count_d = count_q + CNT_W'(1);
        if (fix_en) begin
            hi_d = hi_res;
            lo_d = lo_res;
        end else if (idle_wr) begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        if (load_en) begin
            is_div_q  <= is_div;
            neg_res_q <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_q <= signed_op & a[WIDTH-1];
            dbz_q     <= (b == '0);
            mcand_q   <= is_div ? b_mag : a_mag;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
